// File: rtl/usb_packet_assembler.sv
// usb_packet_assembler
// Collects PAYLOAD_BYTES payload bytes plus a trailing USB CRC16 from a byte
// stream, checks the CRC on the fly and hands good payloads out as one wide
// word over a valid/ready handshake. Bad, truncated or overrun packets are
// dropped and reported by one-cycle error pulses and a saturating counter.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   byte_in      received byte, sampled when byte_valid=1
//   byte_valid   one-cycle strobe per byte, always accepted
//   data_out     last good payload, byte 0 at [7:0]
//   out_valid    data_out holds an undelivered packet
//   out_ready    consumer accepts data_out when out_valid & out_ready
//   crc_err      pulse: packet failed CRC
//   timeout_err  pulse: packet aborted by inter-byte timeout
//   overrun_err  pulse: good packet dropped, previous one still pending
//   err_count    saturating count of all error pulses
module usb_packet_assembler #(
  parameter int unsigned PAYLOAD_BYTES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  output logic [8*PAYLOAD_BYTES-1:0]   data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         crc_err,
  output logic                         timeout_err,
  output logic                         overrun_err,
  output logic [7:0]                   err_count
);

  localparam int unsigned TOTAL_BYTES = PAYLOAD_BYTES + 2;
  localparam int unsigned CNT_W       = $clog2(PAYLOAD_BYTES + 3);
  localparam int unsigned IDLE_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DATA_W      = 8 * PAYLOAD_BYTES;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE = 16'hB001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [15:0]         crc;
  logic [DATA_W-1:0]   rx_buf;

  logic                start_pkt;
  logic                recv_byte;
  logic                timeout_hit;
  logic                good_pkt;
  logic                bad_pkt;
  logic                load_out;
  logic                overrun_hit;
  logic                err_event;
  logic                wr_en;
  logic [CNT_W-1:0]    wr_idx;
  logic [15:0]         crc_next;

  // Reflected CRC16 (poly 0xA001), one byte per call, LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_next  = state;
    start_pkt   = 1'b0;
    recv_byte   = 1'b0;
    timeout_hit = 1'b0;
    good_pkt    = 1'b0;
    bad_pkt     = 1'b0;
    case (state)
      IDLE: begin
        if (byte_valid) begin
          start_pkt  = 1'b1;
          state_next = RECV;
        end
      end
      RECV: begin
        // An arriving byte wins over an expiring idle counter
        if (byte_valid) begin
          recv_byte = 1'b1;
          if (cnt == CNT_W'(TOTAL_BYTES - 1)) state_next = CHECK;
        end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      CHECK: begin
        if (crc == CRC_RESIDUE) good_pkt = 1'b1;
        else                    bad_pkt  = 1'b1;
        // A byte in CHECK opens the next packet immediately
        if (byte_valid) begin
          start_pkt  = 1'b1;
          state_next = RECV;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath helpers
  always_comb begin
    load_out    = good_pkt && (!out_valid || out_ready);
    overrun_hit = good_pkt && out_valid && !out_ready;
    err_event   = timeout_hit || bad_pkt || overrun_hit;
    wr_idx      = start_pkt ? '0 : cnt;
    wr_en       = start_pkt || (recv_byte && (cnt < CNT_W'(PAYLOAD_BYTES)));
    crc_next    = crc16_byte(start_pkt ? CRC_INIT : crc, byte_in);
  end

  // Byte counter, idle counter and running CRC
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idle_cnt <= '0;
      crc      <= CRC_INIT;
    end else if (start_pkt) begin
      cnt      <= CNT_W'(1);
      idle_cnt <= '0;
      crc      <= crc_next;
    end else if (recv_byte) begin
      cnt      <= cnt + CNT_W'(1);
      idle_cnt <= '0;
      crc      <= crc_next;
    end else if (timeout_hit || state == CHECK) begin
      cnt      <= '0;
      idle_cnt <= '0;
      crc      <= CRC_INIT;
    end else if (state == RECV) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Receive buffer; CRC bytes are never stored
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf <= '0;
    end else begin
      for (int k = 0; k < int'(PAYLOAD_BYTES); k++) begin
        if (wr_en && wr_idx == CNT_W'(k)) rx_buf[8*k +: 8] <= byte_in;
      end
    end
  end

  // Output word and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (load_out) begin
      data_out  <= rx_buf;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error pulses and saturating counter
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      crc_err     <= bad_pkt;
      timeout_err <= timeout_hit;
      overrun_err <= overrun_hit;
      if (err_event && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_usb_packet_assembler.sv
// Scoreboard bench for usb_packet_assembler (PAYLOAD_BYTES=9, TIMEOUT_CYCLES=100).
module tb_usb_packet_assembler;

  localparam int unsigned PB = 9;
  localparam int unsigned DW = 8 * PB;

  logic          clk;
  logic          rst;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          out_ready;
  logic          crc_err;
  logic          timeout_err;
  logic          overrun_err;
  logic [7:0]    err_count;

  int checks;
  int errors;

  logic [DW-1:0] pkt_q[$];
  logic [2:0]    err_q[$];

  localparam logic [2:0] EV_CRC     = 3'b100;
  localparam logic [2:0] EV_TIMEOUT = 3'b010;
  localparam logic [2:0] EV_OVERRUN = 3'b001;

  usb_packet_assembler #(
    .PAYLOAD_BYTES (PB),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .crc_err    (crc_err),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // MODBUS-style running CRC: XOR whole byte in, then shift 8 times
  function automatic logic [15:0] model_crc(input logic [DW-1:0] p);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < int'(PB); k++) begin
      c = c ^ {8'h00, p[8*k +: 8]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  // mode: 0 good+delivered, 1 bad CRC, 2 good but overrun, 3 good, no expectation
  task automatic send_pkt(input logic [DW-1:0] p, input int mode);
    logic [15:0] tx;
    tx = ~model_crc(p);
    if (mode == 1) tx[15] = ~tx[15];
    case (mode)
      0: pkt_q.push_back(p);
      1: err_q.push_back(EV_CRC);
      2: err_q.push_back(EV_OVERRUN);
      default: ;
    endcase
    for (int k = 0; k < int'(PB); k++) send_byte(p[8*k +: 8]);
    send_byte(tx[7:0]);
    send_byte(tx[15:8]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, data_out, '0);
    check({tag, "_out_valid"}, DW'(out_valid), '0);
    check({tag, "_err_pulses"}, DW'({crc_err, timeout_err, overrun_err}), '0);
    check({tag, "_err_count"}, DW'(err_count), '0);
  endtask

  // Monitor: pops and compares whenever the DUT delivers or pulses an error
  logic [DW-1:0] mon_pkt;
  logic [2:0]    mon_ev;
  logic [2:0]    mon_exp;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (pkt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_packet: got data_out %0h, required no delivery", data_out);
        end else begin
          mon_pkt = pkt_q.pop_front();
          check("packet_data", data_out, mon_pkt);
        end
      end
      mon_ev = {crc_err, timeout_err, overrun_err};
      if (mon_ev != 3'b000) begin
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_error: got pulses %b, required none", mon_ev);
        end else begin
          mon_exp = err_q.pop_front();
          check("error_kind", DW'(mon_ev), DW'(mon_exp));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pa, pb, pc, pd;
    int n;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    out_ready  = 1'b1;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // "123456789" with hand-computed USB CRC bytes C8 B4
    pkt_q.push_back(72'h393837363534333231);
    for (int k = 0; k < 9; k++) send_byte(8'h31 + 8'(k));
    send_byte(8'hC8);
    send_byte(8'hB4);
    tick(3);
    check("good_err_count", DW'(err_count), DW'(0));

    // Same packet, corrupted last byte
    err_q.push_back(EV_CRC);
    for (int k = 0; k < 9; k++) send_byte(8'h31 + 8'(k));
    send_byte(8'hC8);
    send_byte(8'hB5);
    check("crc_pulse_early", DW'(crc_err), DW'(0));
    tick(1);
    check("crc_pulse_t2", DW'(crc_err), DW'(1));
    check("crc_err_count", DW'(err_count), DW'(1));
    tick(2);

    // Timeout: 4 bytes then silence
    err_q.push_back(EV_TIMEOUT);
    for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k));
    n = 1;
    while (!timeout_err && n < 300) begin
      tick(1);
      n++;
    end
    check("timeout_latency", DW'(n), DW'(101));
    tick(1);
    check("timeout_err_count", DW'(err_count), DW'(2));
    pa = 72'hA8A7A6A5A4A3A2A1A0;
    send_pkt(pa, 0);
    tick(3);

    // Back-to-back with out_ready=0: first held, second overruns
    out_ready = 1'b0;
    pb = 72'h0102030405060708F0;
    pc = 72'h55AA55AA55AA55AA77;
    send_pkt(pb, 0);
    send_pkt(pc, 2);
    tick(3);
    check("held_out_valid", DW'(out_valid), DW'(1));
    check("held_data_out", data_out, pb);
    check("overrun_err_count", DW'(err_count), DW'(3));
    out_ready = 1'b1;
    tick(1);
    check("cleared_after_accept", DW'(out_valid), DW'(0));
    tick(2);

    // Reset with an output pending and a partial packet in flight
    out_ready = 1'b0;
    send_pkt(72'h112233445566778899, 3);
    for (int k = 0; k < 4; k++) send_byte(8'hE0 + 8'(k));
    check("pending_before_rst", DW'(out_valid), DW'(1));
    rst = 1'b1;
    tick(1);
    check_all_zero("midrst");
    rst = 1'b0;
    out_ready = 1'b1;
    pd = 72'hDEADBEEF0123456789;
    send_pkt(pd, 0);
    tick(3);

    // Saturation of err_count
    for (int i = 0; i < 300; i++) send_pkt(72'h000000000000000000 + DW'(i), 1);
    tick(3);
    check("err_count_saturated", DW'(err_count), DW'(255));
    send_pkt(pa, 0);
    tick(3);
    check("err_count_still_sat", DW'(err_count), DW'(255));

    tick(5);
    check("pkt_queue_drained", DW'(pkt_q.size()), DW'(0));
    check("err_queue_drained", DW'(err_q.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_packet_assembler.md
# usb_packet_assembler

Parametrised packet assembler between the USB byte receiver and the averager bank. It collects a fixed-length payload plus a trailing USB CRC16 from a byte stream and checks the CRC on the fly. A good packet is delivered as one wide word through a valid/ready handshake. Bad, truncated or overrun packets are dropped and reported through error pulses and a saturating error counter.

## Interface
- PAYLOAD_BYTES, default 64: payload bytes per packet. Range 1..255. The CRC adds 2 bytes on top.
- TIMEOUT_CYCLES, default 100: consecutive idle cycles allowed mid-packet before the packet is aborted. Must be ≥1.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- byte_in  in  8  received byte; sampled when byte_valid=1.
- byte_valid  in  1  one-cycle strobe per received byte. There is no backpressure, so the block must always accept it.
- data_out  out  8*PAYLOAD_BYTES  last good payload. The first received byte is at [7:0]. Stable while out_valid=1.
- out_valid  out  1  data_out holds an undelivered packet.
- out_ready  in  1  consumer accepts data_out when out_valid & out_ready.
- crc_err  out  1  one-cycle pulse: packet failed the CRC.
- timeout_err  out  1  one-cycle pulse: packet aborted by inter-byte timeout.
- overrun_err  out  1  one-cycle pulse: good packet dropped because out_valid was still set.
- err_count  out  8  saturating count of all three error events. Holds at 255.

## Operation
- Reset values:
  - All outputs are 0: data_out, out_valid, the three error pulses and err_count.
  - The state machine is in IDLE.
  - The byte counter and the idle counter are 0.
  - The CRC register is 16'hFFFF.
- CRC is USB CRC16 in reflected form:
  - Polynomial 0xA001, init 0xFFFF.
  - Each byte is processed LSB first in a single cycle, combinationally, on acceptance.
  - Both CRC bytes are included in the computation.
  - The packet is good iff the register equals the residue 16'hB001 after the last byte.
- Receive buffer: an 8*PAYLOAD_BYTES register. Payload byte k goes to [8k+7:8k]. CRC bytes are not stored.
- State IDLE:
  - byte_valid → store the byte as byte 0, CRC = update(0xFFFF, byte), count=1, go to RECV.
  - If PAYLOAD_BYTES+2 would equal 1, that is impossible, so no special case is needed.
- State RECV:
  - byte_valid → store the byte if count < PAYLOAD_BYTES, update the CRC, count+1, idle counter=0.
  - When the accepted byte is number PAYLOAD_BYTES+2 (count reaches PAYLOAD_BYTES+2), go to CHECK.
  - No byte → idle counter+1.
  - When the idle counter reaches TIMEOUT_CYCLES: go to IDLE, pulse timeout_err, reset the counters and the CRC.
  - A byte arriving in the same cycle the idle counter would expire takes priority and is accepted normally.
- State CHECK (exactly one cycle):
  - Residue matches and out_valid=0 (or is being consumed this cycle via out_ready) → copy the buffer to data_out and set out_valid.
  - Residue matches and out_valid=1 & out_ready=0 → pulse overrun_err. data_out is unchanged.
  - Residue mismatch → pulse crc_err.
  - Always reset the counters and the CRC.
  - byte_valid in CHECK is handled exactly as in IDLE: it starts the next packet and the next state is RECV. Otherwise the next state is IDLE.
- Output handshake:
  - out_valid clears on the cycle after out_valid & out_ready.
  - out_valid is independent of the receive path, so reception continues while a packet is pending.
- err_count:
  - Increments by 1 per error pulse. At most one error pulse can occur per cycle.
  - Saturates at 255 and never wraps.
- rst asserted at any point, including mid-packet or with out_valid pending: the partial packet and the pending output are discarded and all reset values are restored on the next edge.

## Timing
- Last byte (CRC high byte) presented in cycle t → CHECK in cycle t+1 → out_valid or an error pulse visible in cycle t+2.
- Error pulses are exactly one cycle wide and registered.
- Back-to-back packets with no gap are supported at full rate. The first byte of the next packet may arrive in the CHECK cycle.
- Timeout: the last byte is accepted at cycle t and no further bytes arrive → timeout_err visible at cycle t+TIMEOUT_CYCLES+1.
- out_valid & out_ready in cycle c → out_valid=0 in cycle c+1. A CHECK in cycle c with a good CRC instead gives out_valid=1 with new data in cycle c+1.

## Test plan
- PAYLOAD_BYTES=9, send "123456789" (0x31..0x39) then 0xC8, 0xB4, with out_ready=1 → out_valid for 1 cycle, data_out[7:0]=0x31 and [71:64]=0x39, no errors.
- Same packet but with the last byte 0xB5 → crc_err pulse 2 cycles after the last byte, out_valid stays 0, err_count=1.
- Send 4 bytes, then hold byte_valid=0 with TIMEOUT_CYCLES=100 → timeout_err at the 101st cycle after the 4th byte. Then send a full good packet → accepted normally.
- Two good packets back to back with out_ready=0 → first packet delivered and held; overrun_err on the second; data_out still holds the first packet.
- Send 300 bad-CRC packets → err_count saturates at 255.
- rst mid-packet and while out_valid=1 → all outputs 0 next cycle; a following good packet is delivered correctly.
